arith_issue_arbiter: RTL and testbench
======================================

Name: arith_issue_arbiter

Overview:
- Shares one single-cycle arithmetic unit (ALU) between NUM_REQ issue requesters, e.g. decode lanes.
- Each requester gets a one-entry holding slot with a valid/ready handshake. A round-robin grant loads a registered issue stage that drives the ALU inputs directly.
- Tracks which requester owns each in-flight operation and returns an aligned response ID.
- Keeps sticky overflow/underflow flags per requester.

Parameters:
- NUM_REQ, 2, number of requesters; legal 2..4.
- DATA_W, 16, operand width.
- OPC_W, 7, opcode width.
- ADDR_W, 5, writeback register address width.

Ports:
- clock_i  in  1  sole clock; all state updates on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- flush_i  in  1  synchronous flush of slots and in-flight tracking.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester slot can accept (combinational).
- req_opcode_i  in  NUM_REQ*OPC_W  packed opcodes; requester i at [i*OPC_W +: OPC_W].
- req_pop_i  in  NUM_REQ*DATA_W  packed primary operands.
- req_sop_i  in  NUM_REQ*DATA_W  packed secondary operands.
- req_wbaddr_i  in  NUM_REQ*ADDR_W  packed writeback addresses.
- req_iswb_i  in  NUM_REQ  per-requester writeback request.
- alu_enable_o  out  1  ALU enable.
- alu_opcode_o  out  OPC_W  ALU opcode.
- alu_pop_o  out  DATA_W  ALU primary operand.
- alu_sop_o  out  DATA_W  ALU secondary operand.
- alu_wbaddr_o  out  ADDR_W  ALU writeback address.
- alu_iswb_o  out  1  ALU writeback request.
- alu_status_i  in  2  ALU status: [1] overflow, [0] underflow; valid the cycle after ALU capture.
- resp_valid_o  out  1  ALU result of a granted operation is on the ALU outputs this cycle.
- resp_id_o  out  2  owning requester index of that result.
- sticky_status_o  out  NUM_REQ*2  per-requester sticky {overflow, underflow}.
- status_clear_i  in  NUM_REQ  per-requester sticky clear.

Behaviour:
- Reset (reset_i=1 at an edge):
  - All slots empty; round-robin pointer selects requester 0 first.
  - Every alu_* output is 0; resp_valid_o=0, resp_id_o=0; sticky_status_o all 0.
  - Reset overrides flush_i and all handshakes in the same cycle, including mid-operation: in-flight ops are dropped with no response.
- Handshake:
  - req_ready_o[i] = !slot_valid[i] | grant[i], combinational.
  - Accept on valid & ready at an edge; the slot captures opcode, operands, wbaddr and iswb.
  - A granted slot accepting a new request in the same cycle stays full with the new contents. This gives full throughput for a single active requester.
- Arbitration:
  - Combinational over full slots, round-robin.
  - Search starts at the requester after the last granted one.
  - At most one grant per cycle. The pointer advances only on a grant.
- Issue stage (registered):
  - On a grant, the issue registers load the slot fields and alu_enable_o=1 the next cycle.
  - With no grant, alu_enable_o=0 and the other alu_* outputs hold their values.
  - Latency: accept at edge E0 → alu_enable_o high after E1 (earliest) → resp_valid_o high after E2.
- Owner pipeline:
  - resp_valid_o/resp_id_o are alu_enable_o/grant index delayed one cycle, aligned to the ALU's registered outputs.
- Sticky status:
  - When resp_valid_o=1 and the delayed opcode is 1 (add) or 2 (sub), OR alu_status_i into sticky_status_o[resp_id_o].
  - Opcodes 0 and 3 never update flags; the ALU does not drive status for them.
  - status_clear_i[i] clears flags for requester i. A clear and a set on the same requester in the same cycle: set wins.
- Flush:
  - Empties all slots; next-cycle alu_enable_o=0 and resp_valid_o=0.
  - Accepts in the flush cycle are discarded; req_ready_o stays as computed.
  - Sticky flags and the round-robin pointer are preserved.
- Boundaries:
  - All slots full, continuous valid: strict rotation 0,1,..,NUM_REQ-1,0.
  - resp_id_o is zero-extended for NUM_REQ=2.

Optional Feature:
- Macro: ARB_NOP_FILTER_EN.
- Defined:
  - A request with opcode 0 is accepted (ready per the normal rule) but never written to its slot.
  - It never consumes a grant, never produces alu_enable_o or resp_valid_o, and does not advance the pointer.
- Undefined:
  - NOPs are arbitrated and issued like any other opcode.
  - The ALU itself suppresses their writeback.

Test Plan:
- Reset mid-traffic: assert reset_i while req0 add is in the issue stage → next cycle alu_enable_o=0, resp_valid_o=0, sticky all 0, no response for the dropped op.
- Single requester streaming: req0 valid every cycle with op=1, pop=N, sop=1 for N=1..8 → req_ready_o[0] always 1; alu_enable_o high from 2nd cycle with alu_pop_o=1..8 in order; resp_id_o=0.
- Contention: req0 and req1 valid continuously → grants alternate 0,1,0,1; resp_id_o sequence 0,1,0,1 lagging alu_enable_o by one cycle.
- Sticky: req1 op=1 pop=16'hFFFF sop=16'h0002 with alu_status_i=2'b10 at response → sticky_status_o[3:2]=2'b10. Then status_clear_i[1]=1 → 2'b00. A mul with alu_status_i=2'b11 leaves the flags unchanged.
- Flush: both slots full, pulse flush_i → next cycle alu_enable_o=0, both req_ready_o=1, pointer unchanged on the next grant.
- NOP filter (macro on): req0 op=0 then op=2 → only the op=2 issues; exactly one resp_valid_o pulse. With the macro off → two issues, two responses.

Source files
------------

// File: rtl/arith_issue_arbiter_if.sv
// Request/ALU/response bundle for arith_issue_arbiter.
// slave: the arbiter itself; master: the requesters, ALU and status consumer.
interface arith_issue_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned OPC_W   = 7,
  parameter int unsigned ADDR_W  = 5
);
  logic                        flush_i;
  logic [NUM_REQ-1:0]          req_valid_i;
  logic [NUM_REQ-1:0]          req_ready_o;
  logic [NUM_REQ*OPC_W-1:0]    req_opcode_i;
  logic [NUM_REQ*DATA_W-1:0]   req_pop_i;
  logic [NUM_REQ*DATA_W-1:0]   req_sop_i;
  logic [NUM_REQ*ADDR_W-1:0]   req_wbaddr_i;
  logic [NUM_REQ-1:0]          req_iswb_i;
  logic                        alu_enable_o;
  logic [OPC_W-1:0]            alu_opcode_o;
  logic [DATA_W-1:0]           alu_pop_o;
  logic [DATA_W-1:0]           alu_sop_o;
  logic [ADDR_W-1:0]           alu_wbaddr_o;
  logic                        alu_iswb_o;
  logic [1:0]                  alu_status_i;
  logic                        resp_valid_o;
  logic [1:0]                  resp_id_o;
  logic [NUM_REQ*2-1:0]        sticky_status_o;
  logic [NUM_REQ-1:0]          status_clear_i;

  modport slave (
    input  flush_i, req_valid_i, req_opcode_i, req_pop_i, req_sop_i,
           req_wbaddr_i, req_iswb_i, alu_status_i, status_clear_i,
    output req_ready_o, alu_enable_o, alu_opcode_o, alu_pop_o, alu_sop_o,
           alu_wbaddr_o, alu_iswb_o, resp_valid_o, resp_id_o, sticky_status_o
  );

  modport master (
    output flush_i, req_valid_i, req_opcode_i, req_pop_i, req_sop_i,
           req_wbaddr_i, req_iswb_i, alu_status_i, status_clear_i,
    input  req_ready_o, alu_enable_o, alu_opcode_o, alu_pop_o, alu_sop_o,
           alu_wbaddr_o, alu_iswb_o, resp_valid_o, resp_id_o, sticky_status_o
  );
endinterface

// File: rtl/arith_issue_arbiter.sv
// Round-robin arbiter sharing one single-cycle ALU among NUM_REQ requesters.
// Optional ARB_NOP_FILTER_EN: opcode-0 requests are accepted and dropped.
module arith_issue_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned OPC_W   = 7,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  arith_issue_arbiter_if.slave  bus
);

  logic [NUM_REQ-1:0] slot_valid;
  logic [OPC_W-1:0]   slot_opc  [NUM_REQ];
  logic [DATA_W-1:0]  slot_pop  [NUM_REQ];
  logic [DATA_W-1:0]  slot_sop  [NUM_REQ];
  logic [ADDR_W-1:0]  slot_wb   [NUM_REQ];
  logic [NUM_REQ-1:0] slot_iswb;

  logic [1:0]         rr_last;
  logic [NUM_REQ-1:0] grant_vec;
  logic               grant_any;
  logic [1:0]         grant_idx;
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] load;

  logic [OPC_W-1:0]   sel_opc;
  logic [DATA_W-1:0]  sel_pop;
  logic [DATA_W-1:0]  sel_sop;
  logic [ADDR_W-1:0]  sel_wb;
  logic               sel_iswb;

  logic [1:0]         issue_id;
  logic [OPC_W-1:0]   resp_opc;
  logic [1:0]         sticky [NUM_REQ];
  logic               resp_is_arith;

  // Round-robin: first full slot strictly after the last granted requester.
  always_comb begin
    grant_vec = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!grant_any && slot_valid[i] && (i == ((32'(rr_last) + k) % NUM_REQ))) begin
          grant_vec[i] = 1'b1;
          grant_any    = 1'b1;
          grant_idx    = 2'(i);
        end
      end
    end
  end

  always_comb begin
    ready = '0;
    load  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      ready[i] = !slot_valid[i] || grant_vec[i];
`ifdef ARB_NOP_FILTER_EN
      load[i]  = bus.req_valid_i[i] && ready[i] &&
                 (bus.req_opcode_i[i*OPC_W +: OPC_W] != '0);
`else
      load[i]  = bus.req_valid_i[i] && ready[i];
`endif
    end
  end

  assign bus.req_ready_o = ready;

  always_comb begin
    sel_opc  = '0;
    sel_pop  = '0;
    sel_sop  = '0;
    sel_wb   = '0;
    sel_iswb = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_vec[i]) begin
        sel_opc  = slot_opc[i];
        sel_pop  = slot_pop[i];
        sel_sop  = slot_sop[i];
        sel_wb   = slot_wb[i];
        sel_iswb = slot_iswb[i];
      end
    end
  end

  // A granted slot that loads in the same cycle stays full with new contents.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      slot_valid <= '0;
      slot_iswb  <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        slot_opc[i] <= '0;
        slot_pop[i] <= '0;
        slot_sop[i] <= '0;
        slot_wb[i]  <= '0;
      end
    end else if (bus.flush_i) begin
      slot_valid <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (load[i]) begin
          slot_valid[i] <= 1'b1;
          slot_opc[i]   <= bus.req_opcode_i[i*OPC_W +: OPC_W];
          slot_pop[i]   <= bus.req_pop_i[i*DATA_W +: DATA_W];
          slot_sop[i]   <= bus.req_sop_i[i*DATA_W +: DATA_W];
          slot_wb[i]    <= bus.req_wbaddr_i[i*ADDR_W +: ADDR_W];
          slot_iswb[i]  <= bus.req_iswb_i[i];
        end else if (grant_vec[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      bus.alu_enable_o <= 1'b0;
      bus.alu_opcode_o <= '0;
      bus.alu_pop_o    <= '0;
      bus.alu_sop_o    <= '0;
      bus.alu_wbaddr_o <= '0;
      bus.alu_iswb_o   <= 1'b0;
      issue_id         <= '0;
      rr_last          <= 2'(NUM_REQ - 1);
    end else if (grant_any && !bus.flush_i) begin
      bus.alu_enable_o <= 1'b1;
      bus.alu_opcode_o <= sel_opc;
      bus.alu_pop_o    <= sel_pop;
      bus.alu_sop_o    <= sel_sop;
      bus.alu_wbaddr_o <= sel_wb;
      bus.alu_iswb_o   <= sel_iswb;
      issue_id         <= grant_idx;
      rr_last          <= grant_idx;
    end else begin
      bus.alu_enable_o <= 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      bus.resp_valid_o <= 1'b0;
      bus.resp_id_o    <= '0;
      resp_opc         <= '0;
    end else begin
      bus.resp_valid_o <= bus.alu_enable_o && !bus.flush_i;
      bus.resp_id_o    <= issue_id;
      resp_opc         <= bus.alu_opcode_o;
    end
  end

  assign resp_is_arith = (resp_opc == OPC_W'(1)) || (resp_opc == OPC_W'(2));

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) sticky[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (bus.resp_valid_o && (bus.resp_id_o == 2'(i)) && resp_is_arith)
          sticky[i] <= sticky[i] | bus.alu_status_i;
        else if (bus.status_clear_i[i])
          sticky[i] <= '0;
      end
    end
  end

  always_comb begin
    bus.sticky_status_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) bus.sticky_status_o[2*i +: 2] = sticky[i];
  end

endmodule

// File: tb/tb_arith_issue_arbiter.sv
// Self-checking bench for arith_issue_arbiter: directed tables/sequences plus
// randomized traffic compared against a transaction-level reference model.
module tb_arith_issue_arbiter;
  localparam int N  = 2;
  localparam int DW = 16;
  localparam int OW = 7;
  localparam int AW = 5;

  typedef struct packed {
    logic [OW-1:0] opc;
    logic [DW-1:0] pop;
    logic [DW-1:0] sop;
    logic [AW-1:0] wb;
    logic          iswb;
  } op_t;

  typedef struct {
    logic          v;
    logic [DW-1:0] pop;
    logic          exp_en;
    logic [DW-1:0] exp_apop;
    logic          exp_rv;
  } stream_vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   en_pulses = 0;
  int   rv_pulses = 0;

  arith_issue_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .OPC_W(OW), .ADDR_W(AW)) bus ();

  arith_issue_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OPC_W(OW), .ADDR_W(AW)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: one optional op per slot, the issued op, the
  // response in flight and the sticky flags.
  bit         m_full [N];
  op_t        m_slot [N];
  int         m_last;
  bit         m_en;
  op_t        m_alu;
  int         m_id;
  bit         m_rv;
  int         m_rid;
  logic [OW-1:0] m_ropc;
  logic [1:0] m_sticky [N];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 1'b0;
      m_slot[i] = '0;
      m_sticky[i] = '0;
    end
    m_last = N - 1;
    m_en = 1'b0;
    m_alu = '0;
    m_id = 0;
    m_rv = 1'b0;
    m_rid = 0;
    m_ropc = '0;
  endtask

  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      int c = (m_last + k) % N;
      if (m_full[c]) return c;
    end
    return -1;
  endfunction

  function automatic op_t in_req(int i);
    op_t r;
    r.opc  = bus.req_opcode_i[i*OW +: OW];
    r.pop  = bus.req_pop_i[i*DW +: DW];
    r.sop  = bus.req_sop_i[i*DW +: DW];
    r.wb   = bus.req_wbaddr_i[i*AW +: AW];
    r.iswb = bus.req_iswb_i[i];
    return r;
  endfunction

  task automatic model_edge();
    int  g;
    bit  acc;
    bit  keep;
    op_t r;
    if (rst) begin
      model_init();
      return;
    end
    g = pick();
    for (int i = 0; i < N; i++) begin
      if (m_rv && m_rid == i && (m_ropc == 1 || m_ropc == 2))
        m_sticky[i] = m_sticky[i] | bus.alu_status_i;
      else if (bus.status_clear_i[i])
        m_sticky[i] = '0;
    end
    m_rv   = m_en && !bus.flush_i;
    m_rid  = m_id;
    m_ropc = m_alu.opc;
    if (!bus.flush_i && g >= 0) begin
      m_alu  = m_slot[g];
      m_en   = 1'b1;
      m_id   = g;
      m_last = g;
    end else begin
      m_en = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      r    = in_req(i);
      acc  = bus.req_valid_i[i] && (!m_full[i] || g == i);
      keep = acc;
`ifdef ARB_NOP_FILTER_EN
      if (r.opc == 0) keep = 1'b0;
`endif
      if (bus.flush_i) m_full[i] = 1'b0;
      else if (keep) begin
        m_full[i] = 1'b1;
        m_slot[i] = r;
      end else if (g == i) m_full[i] = 1'b0;
    end
  endtask

  // Called just after a rising edge with inputs already driven.
  task automatic step();
    int g;
    logic [N-1:0] exp_ready;
    logic [2*N-1:0] exp_sticky;
    #4;
    g = pick();
    for (int i = 0; i < N; i++) exp_ready[i] = !m_full[i] || (g == i);
    check("req_ready", bus.req_ready_o, exp_ready);
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < N; i++) exp_sticky[2*i +: 2] = m_sticky[i];
    check("alu_enable", bus.alu_enable_o, m_en);
    check("alu_opcode", bus.alu_opcode_o, m_alu.opc);
    check("alu_pop", bus.alu_pop_o, m_alu.pop);
    check("alu_sop", bus.alu_sop_o, m_alu.sop);
    check("alu_wbaddr", bus.alu_wbaddr_o, m_alu.wb);
    check("alu_iswb", bus.alu_iswb_o, m_alu.iswb);
    check("resp_valid", bus.resp_valid_o, m_rv);
    if (m_rv) check("resp_id", bus.resp_id_o, m_rid);
    check("sticky", bus.sticky_status_o, exp_sticky);
    if (bus.alu_enable_o === 1'b1) en_pulses++;
    if (bus.resp_valid_o === 1'b1) rv_pulses++;
  endtask

  task automatic set_req(int i, logic v, logic [OW-1:0] op, logic [DW-1:0] pop,
                         logic [DW-1:0] sop, logic [AW-1:0] wb, logic iswb);
    bus.req_valid_i[i]           = v;
    bus.req_opcode_i[i*OW +: OW] = op;
    bus.req_pop_i[i*DW +: DW]    = pop;
    bus.req_sop_i[i*DW +: DW]    = sop;
    bus.req_wbaddr_i[i*AW +: AW] = wb;
    bus.req_iswb_i[i]            = iswb;
  endtask

  task automatic idle();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0, '0, '0, 1'b0);
    bus.flush_i        = 1'b0;
    bus.status_clear_i = '0;
    bus.alu_status_i   = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  stream_vec_t tbl [11];
  int exp_nops;

  initial begin
    for (int c = 0; c < 11; c++) begin
      tbl[c].v        = (c <= 7);
      tbl[c].pop      = (c <= 7) ? DW'(c + 1) : '0;
      tbl[c].exp_en   = (c >= 1 && c <= 8);
      tbl[c].exp_apop = (c == 0) ? '0 : ((c <= 8) ? DW'(c) : DW'(8));
      tbl[c].exp_rv   = (c >= 2 && c <= 9);
    end

    idle();
    rst = 1'b1;
    @(posedge clk);
    model_init();
    #1;
    step();
    rst = 1'b0;
    check("reset_alu_enable", bus.alu_enable_o, 1'b0);
    check("reset_alu_pop", bus.alu_pop_o, 16'h0);
    check("reset_resp_valid", bus.resp_valid_o, 1'b0);
    check("reset_resp_id", bus.resp_id_o, 2'd0);
    check("reset_sticky", bus.sticky_status_o, 4'h0);

    // Single requester streaming
    for (int c = 0; c < 11; c++) begin
      set_req(0, tbl[c].v, 7'd1, tbl[c].pop, 16'd1, 5'd3, 1'b1);
      step();
      check("stream_en", bus.alu_enable_o, tbl[c].exp_en);
      check("stream_pop", bus.alu_pop_o, tbl[c].exp_apop);
      check("stream_rv", bus.resp_valid_o, tbl[c].exp_rv);
      if (tbl[c].exp_rv) check("stream_rid", bus.resp_id_o, 2'd0);
    end

    // Contention, then flush with valids still high
    do_reset();
    set_req(0, 1'b1, 7'd1, 16'hA000, 16'd1, 5'd1, 1'b1);
    set_req(1, 1'b1, 7'd2, 16'hB000, 16'd2, 5'd2, 1'b1);
    for (int k = 0; k < 7; k++) begin
      step();
      if (k >= 1) begin
        check("cont_en", bus.alu_enable_o, 1'b1);
        check("cont_pop", bus.alu_pop_o, ((k - 1) % 2 == 0) ? 16'hA000 : 16'hB000);
      end
      if (k >= 2) begin
        check("cont_rv", bus.resp_valid_o, 1'b1);
        check("cont_rid", bus.resp_id_o, 2'((k - 2) % 2));
      end
    end
    bus.flush_i = 1'b1;
    step();
    check("flush_en", bus.alu_enable_o, 1'b0);
    check("flush_rv", bus.resp_valid_o, 1'b0);
    bus.flush_i = 1'b0;
    step();
    check("flush_discard_en", bus.alu_enable_o, 1'b0);
    step();
    check("flush_next_en", bus.alu_enable_o, 1'b1);
    check("flush_next_pop", bus.alu_pop_o, 16'hA000);

    // Sticky set / clear / non-arith op
    do_reset();
    set_req(1, 1'b1, 7'd1, 16'hFFFF, 16'h0002, 5'd4, 1'b1);
    bus.alu_status_i = 2'b10;
    step();
    set_req(1, 1'b0, 7'd1, 16'hFFFF, 16'h0002, 5'd4, 1'b1);
    step();
    step();
    check("sticky_rv", bus.resp_valid_o, 1'b1);
    check("sticky_rid", bus.resp_id_o, 2'd1);
    step();
    check("sticky_set", bus.sticky_status_o, 4'b1000);
    bus.status_clear_i = 2'b10;
    step();
    bus.status_clear_i = 2'b00;
    check("sticky_clear", bus.sticky_status_o, 4'b0000);
    set_req(1, 1'b1, 7'd3, 16'd5, 16'd7, 5'd4, 1'b1);
    bus.alu_status_i = 2'b11;
    step();
    set_req(1, 1'b0, 7'd3, 16'd5, 16'd7, 5'd4, 1'b1);
    for (int k = 0; k < 3; k++) step();
    check("sticky_mul", bus.sticky_status_o, 4'b0000);

    // NOP followed by sub from requester 0
    do_reset();
    en_pulses = 0;
    rv_pulses = 0;
    set_req(0, 1'b1, 7'd0, 16'd1, 16'd1, 5'd1, 1'b0);
    step();
    set_req(0, 1'b1, 7'd2, 16'd2, 16'd1, 5'd1, 1'b1);
    step();
    set_req(0, 1'b0, 7'd0, 16'd0, 16'd0, 5'd0, 1'b0);
    for (int k = 0; k < 5; k++) step();
`ifdef ARB_NOP_FILTER_EN
    exp_nops = 1;
`else
    exp_nops = 2;
`endif
    check("nop_issues", 64'(en_pulses), 64'(exp_nops));
    check("nop_responses", 64'(rv_pulses), 64'(exp_nops));

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst                = ($urandom_range(0, 99) == 0);
      bus.flush_i        = ($urandom_range(0, 19) == 0);
      bus.alu_status_i   = 2'($urandom);
      for (int i = 0; i < N; i++) begin
        bus.status_clear_i[i] = ($urandom_range(0, 11) == 0);
        set_req(i, ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 5) == 0) ? OW'($urandom) : OW'($urandom_range(0, 3)),
                DW'($urandom), DW'($urandom), AW'($urandom), 1'($urandom));
      end
      step();
    end

    // Reset while requester 0's add sits in the issue stage
    rst = 1'b0;
    idle();
    bus.alu_status_i = 2'b11;
    set_req(0, 1'b1, 7'd1, 16'd3, 16'd4, 5'd2, 1'b1);
    step();
    set_req(0, 1'b0, 7'd1, 16'd3, 16'd4, 5'd2, 1'b1);
    step();
    check("midrst_issue", bus.alu_enable_o, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_en", bus.alu_enable_o, 1'b0);
    check("midrst_rv", bus.resp_valid_o, 1'b0);
    check("midrst_sticky", bus.sticky_status_o, 4'h0);
    step();
    check("midrst_no_resp", bus.resp_valid_o, 1'b0);
    check("midrst_sticky2", bus.sticky_status_o, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
